// File: rtl/reg_file_pkg.sv
// Shared constants for the datapath register bank and its users.
package reg_file_pkg;

  localparam int unsigned BYTE          = 8;
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // Bank-select codes used by datapath blocks that front several reg_file instances.
  typedef enum logic [1:0] {
    BankGpr     = 2'd0,
    BankFpr     = 2'd1,
    BankCsr     = 2'd2,
    BankScratch = 2'd3
  } bank_sel_e;

  function automatic int unsigned num_bytes(int unsigned width);
    return width / BYTE;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write/read bus of the register bank; master drives addresses and write data.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                   clr;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH/BYTE-1:0]  wbe;
  logic [WIDTH-1:0]       wdata;
  logic [AW-1:0]          raddr_a;
  logic [WIDTH-1:0]       rdata_a;
  logic                   rvld_a;
  logic [AW-1:0]          raddr_b;
  logic [WIDTH-1:0]       rdata_b;
  logic                   rvld_b;
  logic [DEPTH-1:0]       written;

  modport master (
    output clr, we, waddr, wbe, wdata, raddr_a, raddr_b,
    input  rdata_a, rvld_a, rdata_b, rvld_b, written
  );

  modport slave (
    input  clr, we, waddr, wbe, wdata, raddr_a, raddr_b,
    output rdata_a, rvld_a, rdata_b, rvld_b, written
  );

endinterface

// File: rtl/be_reg.sv
// Single byte-enabled load register with async active-low reset and sync clear.
module be_reg
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [WIDTH/BYTE-1:0] be,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q
);
  localparam int unsigned NB = num_bytes(WIDTH);

  logic [WIDTH-1:0] data_d, data_q;

  // Clear wins over a load in the same cycle.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (ld) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) data_d[i*BYTE +: BYTE] = d[i*BYTE +: BYTE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file.sv
// Register bank: byte-enabled write port, two combinational read ports with
// optional write bypass, optional hardwired-zero entry 0 and per-entry written flags.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = num_bytes(WIDTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            written_d, written_q;
  logic                        wr_ok;
  logic                        byp_ok;
  logic                        hit_a, hit_b;
  logic [WIDTH-1:0]            wmerge;

  // A write counts only if it touches at least one byte of a real entry.
  assign wr_ok  = bus.we && (|bus.wbe) && !(ZERO_R0 && (bus.waddr == '0));
  assign byp_ok = BYPASS && rst_n && !bus.clr && wr_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : gen_entry
    if (ZERO_R0 && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_reg
      be_reg #(
        .WIDTH (WIDTH)
      ) u_entry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .ld    (wr_ok && (bus.waddr == AW'(i))),
        .be    (bus.wbe),
        .d     (bus.wdata),
        .q     (mem[i])
      );
    end
  end

  always_comb begin
    written_d = written_q;
    if (bus.clr) begin
      written_d = '0;
    end else if (wr_ok) begin
      written_d[bus.waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) written_q <= '0;
    else        written_q <= written_d;
  end

  assign bus.written = written_q;

  // Both read ports share one merge of the entry being written.
  always_comb begin
    wmerge = mem[bus.waddr];
    for (int unsigned i = 0; i < NB; i++) begin
      if (bus.wbe[i]) wmerge[i*BYTE +: BYTE] = bus.wdata[i*BYTE +: BYTE];
    end
  end

  always_comb begin
    hit_a       = byp_ok && (bus.raddr_a == bus.waddr);
    hit_b       = byp_ok && (bus.raddr_b == bus.waddr);
    bus.rdata_a = hit_a ? wmerge : mem[bus.raddr_a];
    bus.rdata_b = hit_b ? wmerge : mem[bus.raddr_b];
    bus.rvld_a  = hit_a || written_q[bus.raddr_a];
    bus.rvld_b  = hit_b || written_q[bus.raddr_b];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: default build plus ZERO_R0=0 and BYPASS=0 variants.
module tb_reg_file;
  localparam int unsigned W = 32;
  localparam int unsigned D = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic         vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  reg_file_if #(.WIDTH(W), .DEPTH(D)) bus ();
  reg_file_if #(.WIDTH(W), .DEPTH(D)) bus_nz ();
  reg_file_if #(.WIDTH(W), .DEPTH(D)) bus_nb ();

  // All three builds see identical stimulus.
  assign bus_nz.clr = bus.clr;     assign bus_nb.clr = bus.clr;
  assign bus_nz.we = bus.we;       assign bus_nb.we = bus.we;
  assign bus_nz.waddr = bus.waddr; assign bus_nb.waddr = bus.waddr;
  assign bus_nz.wbe = bus.wbe;     assign bus_nb.wbe = bus.wbe;
  assign bus_nz.wdata = bus.wdata; assign bus_nb.wdata = bus.wdata;
  assign bus_nz.raddr_a = bus.raddr_a; assign bus_nb.raddr_a = bus.raddr_a;
  assign bus_nz.raddr_b = bus.raddr_b; assign bus_nb.raddr_b = bus.raddr_b;

  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_nz (
    .clk (clk), .rst_n (rst_n), .bus (bus_nz)
  );
  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk (clk), .rst_n (rst_n), .bus (bus_nb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [W-1:0] model_mem [D];
  logic [D-1:0] model_wr;

  task automatic model_clear();
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    model_wr = '0;
  endtask

  // Model of the ZERO_R0=1 builds; updated at the edge the write lands on.
  task automatic apply_write(input logic [3:0] addr, input logic [3:0] be,
                             input logic [W-1:0] data);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = addr; bus.wbe = be; bus.wdata = data;
    @(posedge clk);
    if (addr != 0 && be != 0 && !bus.clr) begin
      for (int i = 0; i < 4; i++) if (be[i]) model_mem[addr][8*i +: 8] = data[8*i +: 8];
      model_wr[addr] = 1'b1;
    end
    #1;
    bus.we = 1'b0; bus.wbe = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clr = 0; bus.we = 0; bus.waddr = '0; bus.wbe = '0; bus.wdata = '0;
    bus.raddr_a = '0; bus.raddr_b = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      bus.raddr_a = 4'(a); bus.raddr_b = 4'(15 - a);
      exp_q.push_back('{data: '0, vld: 1'b0});
      exp_q.push_back('{data: '0, vld: 1'b0});
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.rdata_a !== e.data || bus.rvld_a !== e.vld) begin
        errors++;
        $display("FAIL reset_read_a addr=%0d got=%h/%b exp=%h/%b", a, bus.rdata_a, bus.rvld_a,
                 e.data, e.vld);
      end
      e = exp_q.pop_front(); checks++;
      if (bus.rdata_b !== e.data || bus.rvld_b !== e.vld) begin
        errors++;
        $display("FAIL reset_read_b addr=%0d got=%h/%b exp=%h/%b", 15 - a, bus.rdata_b,
                 bus.rvld_b, e.data, e.vld);
      end
    end
    checks++;
    if (bus.written !== 16'h0000) begin
      errors++; $display("FAIL reset_written got=%h exp=0000", bus.written);
    end
  endtask

  task automatic test_write();
    apply_write(4'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    bus.raddr_a = 4'd5;
    exp_q.push_back('{data: 32'hDEADBEEF, vld: 1'b1});
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rdata_a !== e.data || bus.rvld_a !== e.vld) begin
      errors++;
      $display("FAIL write_read got=%h/%b exp=%h/%b", bus.rdata_a, bus.rvld_a, e.data, e.vld);
    end
    checks++;
    if (bus.written !== 16'h0020) begin
      errors++; $display("FAIL write_written got=%h exp=0020", bus.written);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 4'd5; bus.wbe = 4'b0101; bus.wdata = 32'h11223344;
    bus.raddr_a = 4'd5; bus.raddr_b = 4'd5;
    exp_q.push_back('{data: 32'hDE22BE44, vld: 1'b1});
    exp_q.push_back('{data: 32'hDE22BE44, vld: 1'b1});
    exp_q.push_back('{data: 32'hDEADBEEF, vld: 1'b1});
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rdata_b !== e.data || bus.rvld_b !== e.vld) begin
      errors++;
      $display("FAIL bypass_b got=%h/%b exp=%h/%b", bus.rdata_b, bus.rvld_b, e.data, e.vld);
    end
    e = exp_q.pop_front(); checks++;
    if (bus.rdata_a !== e.data || bus.rvld_a !== e.vld) begin
      errors++;
      $display("FAIL bypass_a got=%h/%b exp=%h/%b", bus.rdata_a, bus.rvld_a, e.data, e.vld);
    end
    e = exp_q.pop_front(); checks++;
    if (bus_nb.rdata_b !== e.data) begin
      errors++; $display("FAIL nobypass_old got=%h exp=%h", bus_nb.rdata_b, e.data);
    end
    @(posedge clk);
    model_mem[5] = 32'hDE22BE44;
    #1 bus.we = 1'b0; bus.wbe = '0;
    @(negedge clk);
    exp_q.push_back('{data: 32'hDE22BE44, vld: 1'b1});
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus_nb.rdata_b !== e.data || dut.bus.rdata_a !== e.data) begin
      errors++;
      $display("FAIL bypass_stored got=%h,%h exp=%h", bus_nb.rdata_b, bus.rdata_a, e.data);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 4'd0; bus.wbe = 4'hF; bus.wdata = 32'hFFFFFFFF;
    bus.raddr_a = 4'd0;
    #1; checks++;
    if (bus.rdata_a !== 32'h0 || bus.rvld_a !== 1'b0) begin
      errors++; $display("FAIL zero_bypass got=%h/%b exp=0/0", bus.rdata_a, bus.rvld_a);
    end
    @(posedge clk);
    #1 bus.we = 1'b0; bus.wbe = '0;
    @(negedge clk);
    #1; checks++;
    if (bus.rdata_a !== 32'h0 || bus.rvld_a !== 1'b0 || bus.written[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_entry got=%h/%b/%b exp=0/0/0", bus.rdata_a, bus.rvld_a, bus.written[0]);
    end
    checks++;
    if (bus_nz.rdata_a !== 32'hFFFFFFFF || bus_nz.rvld_a !== 1'b1 || bus_nz.written[0] !== 1'b1)
    begin
      errors++;
      $display("FAIL nonzero_entry0 got=%h/%b/%b exp=ffffffff/1/1", bus_nz.rdata_a,
               bus_nz.rvld_a, bus_nz.written[0]);
    end
  endtask

  task automatic test_wbe_zero();
    apply_write(4'd7, 4'h0, 32'h12345678);
    @(negedge clk);
    bus.raddr_b = 4'd7;
    #1; checks++;
    if (bus.rdata_b !== 32'h0 || bus.rvld_b !== 1'b0 || bus.written !== 16'h0020) begin
      errors++;
      $display("FAIL wbe_zero got=%h/%b/%h exp=0/0/0020", bus.rdata_b, bus.rvld_b, bus.written);
    end
  endtask

  task automatic test_clear();
    apply_write(4'd3, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    bus.clr = 1'b1; bus.we = 1'b1; bus.waddr = 4'd3; bus.wbe = 4'hF; bus.wdata = 32'h0BADBEEF;
    bus.raddr_a = 4'd3;
    #1; checks++;
    if (bus.rdata_a !== 32'hCAFEF00D) begin
      errors++; $display("FAIL clear_no_bypass got=%h exp=cafef00d", bus.rdata_a);
    end
    @(posedge clk);
    #1 bus.clr = 1'b0; bus.we = 1'b0; bus.wbe = '0;
    model_clear();
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      bus.raddr_a = 4'(a);
      #1; checks++;
      if (bus.rdata_a !== 32'h0 || bus_nz.rdata_a !== 32'h0 || bus.rvld_a !== 1'b0) begin
        errors++;
        $display("FAIL clear_read addr=%0d got=%h,%h/%b exp=0", a, bus.rdata_a, bus_nz.rdata_a,
                 bus.rvld_a);
      end
    end
    checks++;
    if (bus.written !== 16'h0 || bus_nz.written !== 16'h0) begin
      errors++; $display("FAIL clear_written got=%h,%h exp=0", bus.written, bus_nz.written);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a < D; a++) begin
      apply_write(4'(a), 4'($urandom_range(1, 15)), $urandom);
    end
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      bus.raddr_a = 4'(a); bus.raddr_b = 4'(15 - a);
      exp_q.push_back('{data: model_mem[a], vld: model_wr[a]});
      exp_q.push_back('{data: model_mem[15 - a], vld: model_wr[15 - a]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.rdata_a !== e.data || bus.rvld_a !== e.vld || bus_nb.rdata_a !== e.data) begin
        errors++;
        $display("FAIL b2b_read_a addr=%0d got=%h/%b nb=%h exp=%h/%b", a, bus.rdata_a,
                 bus.rvld_a, bus_nb.rdata_a, e.data, e.vld);
      end
      e = exp_q.pop_front(); checks++;
      if (bus.rdata_b !== e.data || bus.rvld_b !== e.vld) begin
        errors++;
        $display("FAIL b2b_read_b addr=%0d got=%h/%b exp=%h/%b", 15 - a, bus.rdata_b,
                 bus.rvld_b, e.data, e.vld);
      end
    end
    checks++;
    if (bus.written !== 16'hFFFE) begin
      errors++; $display("FAIL b2b_written got=%h exp=fffe", bus.written);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.raddr_a = 4'd9; bus.raddr_b = 4'd15;
    #1; checks++;
    if (bus.rdata_a !== model_mem[9] || bus.rdata_b !== model_mem[15]) begin
      errors++;
      $display("FAIL areset_preload got=%h,%h exp=%h,%h", bus.rdata_a, bus.rdata_b,
               model_mem[9], model_mem[15]);
    end
    #1 rst_n = 1'b0;
    #1; checks++;
    if (bus.rdata_a !== 32'h0 || bus.rdata_b !== 32'h0 || bus.rvld_a !== 1'b0 ||
        bus.rvld_b !== 1'b0 || bus.written !== 16'h0 || bus_nb.rdata_a !== 32'h0) begin
      errors++;
      $display("FAIL areset_immediate got=%h,%h/%b%b/%h exp=0", bus.rdata_a, bus.rdata_b,
               bus.rvld_a, bus.rvld_b, bus.written);
    end
    #1 rst_n = 1'b1;
    model_clear();
    apply_write(4'd9, 4'hF, 32'hA5A5A5A5);
    @(negedge clk);
    #1; checks++;
    if (bus.rdata_a !== 32'hA5A5A5A5 || bus.rvld_a !== 1'b1 || bus.written !== 16'h0200) begin
      errors++;
      $display("FAIL areset_first_write got=%h/%b/%h exp=a5a5a5a5/1/0200", bus.rdata_a,
               bus.rvld_a, bus.written);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_zero();
    test_wbe_zero();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
